gpio_intr_ctrl: RTL and testbench
=================================

Name: gpio_intr_ctrl

Overview:
Consumes the per-pin edge events (gpio_int_event) from the GPIO interrupt generator and holds them in sticky pending status bits. Provides software mask, write-1-to-clear and write-1-to-set through a simple register-bus slave. Drives a single registered level interrupt to the CPU interrupt controller. Sits between the GPIO edge detector and the core IRQ mux.

Parameters:
NB_GPIO, 32, number of GPIO interrupt sources (1..32)
CNT_W, 8, width of the coalescing event counter
TMO_W, 16, width of the coalescing timeout counter

Ports:
mclk  input  1  system clock
h_reset_n  input  1  synchronous active-low reset
gpio_int_event  input  NB_GPIO  one-cycle edge-event pulses, one per pin
reg_cs  input  1  register access request, held until reg_ack
reg_wr  input  1  1 = write, 0 = read
reg_addr  input  2  word address
reg_be  input  4  byte enables (writes only)
reg_wdata  input  32  write data
reg_rdata  output  32  read data, valid with reg_ack
reg_ack  output  1  one-cycle access acknowledge
gpio_irq  output  1  level interrupt to CPU

Behaviour:
- Reset (h_reset_n low at mclk rise): intr_stat=0, intr_mask=0, ctrl=0, reg_ack=0, reg_rdata=0, gpio_irq=0, all counters 0.
- Register map (bits above NB_GPIO-1 read 0, writes ignored):
  0 INTR_STAT: R / W1C, sticky pending bits
  1 INTR_SET: W1S into INTR_STAT; reads return 0
  2 INTR_MASK: R/W, 1 = pin enabled onto gpio_irq
  3 IRQ_CTRL: bit0 global enable (R/W); [15:8] coalesce threshold; [31:16] timeout (coalescing build only, else read 0)
- Byte enables gate every write byte-wise, including W1C and W1S.
- Bus FSM: IDLE -> ACK when reg_cs=1 (write committed on this edge; reg_rdata loaded); ACK -> IDLE unconditionally, reg_ack=1 for exactly that one cycle. A reg_cs still high in IDLE after ACK starts a new access, so minimum access spacing is 2 cycles.
- Status update each cycle: stat_next = (stat & ~w1c) | w1s | gpio_int_event.
  - Same-cycle event and W1C on the same bit: set wins; no event is lost.
  - Events set status regardless of mask; mask affects only gpio_irq.
- gpio_irq is registered: gpio_irq <= ctrl[0] & |(stat & mask). Latency: 1 cycle from status or mask change; 2 cycles from the gpio_int_event pulse.
- Clearing the last masked pending bit deasserts gpio_irq on the cycle after the write edge.
- Synchronous reset mid-access aborts the access: reg_ack is not issued and the write is discarded unless the commit edge has already passed.

Optional Feature:
Macro GPIO_INTR_COALESCE_EN.
- With the macro defined:
  - evt_cnt (CNT_W, saturating) increments by 1 on any cycle with at least one masked event: |(gpio_int_event & mask).
  - tmo_cnt (TMO_W) runs while evt_cnt != 0.
  - gpio_irq asserts when ctrl[0] & |(stat & mask) & (evt_cnt >= thr | tmo_cnt == timeout).
  - thr = 0 or 1 means no coalescing.
  - Both counters clear when stat & mask becomes 0.
  - Once asserted, gpio_irq holds until stat & mask == 0 or ctrl[0] = 0.
- Without the macro: counters are absent, IRQ_CTRL[31:8] read 0, and gpio_irq follows the base equation above.

Decomposition:
- Package gpio_intr_pkg holds:
  - register address localparams: INTR_STAT = 2'd0, INTR_SET = 2'd1, INTR_MASK = 2'd2, IRQ_CTRL = 2'd3
  - bus FSM state enum {IDLE, ACK}
  - IRQ_CTRL field bit positions
- One sub-module, gpio_intr_coalesce: counters and the gate, instantiated only under GPIO_INTR_COALESCE_EN.

Test Plan:
1. Reset, then read all four addresses -> rdata = 0 each; reg_ack high exactly 1 cycle per access.
2. MASK = 0x0000_0001, CTRL = 0x1; pulse gpio_int_event = 0x1 -> STAT = 0x1, gpio_irq high 2 cycles after the pulse; W1C STAT 0x1 -> gpio_irq low on the next cycle.
3. Pulse event bit 5 in the same cycle as W1C of bit 5 -> STAT bit 5 remains 1.
4. MASK = 0; pulse event bit 3 -> STAT = 0x8, gpio_irq stays 0; then write MASK = 0x8 -> gpio_irq high 1 cycle later.
5. Write INTR_SET 0x8000_0000 with reg_be = 4'b1000 -> STAT = 0x8000_0000; same write with reg_be = 4'b0111 -> no change.
6. (GPIO_INTR_COALESCE_EN) CTRL = thr 3, timeout 100, en 1; MASK = all; single event -> gpio_irq rises 100 cycles later; three events on separate cycles -> gpio_irq rises after the third.

Source files
------------

// File: rtl/gpio_intr_pkg.sv
// rtl/gpio_intr_pkg.sv - register map, bus states and IRQ_CTRL fields for gpio_intr_ctrl
package gpio_intr_pkg;

    localparam logic [1:0] INTR_STAT = 2'd0;
    localparam logic [1:0] INTR_SET  = 2'd1;
    localparam logic [1:0] INTR_MASK = 2'd2;
    localparam logic [1:0] IRQ_CTRL  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } bus_state_e;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_THR_LSB = 8;
    localparam int CTRL_THR_MSB = 15;
    localparam int CTRL_TMO_LSB = 16;
    localparam int CTRL_TMO_MSB = 31;

    // Expand the four byte enables into a 32-bit bit mask.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/gpio_intr_coalesce.sv
// rtl/gpio_intr_coalesce.sv - event/timeout coalescing counters and irq gate
//
// Ports:
//   mclk, h_reset_n          clock, synchronous active-low reset
//   evt_i                    per-pin edge-event pulses
//   stat_i, mask_i           current pending status and mask
//   stat_next_i, mask_next_i values status and mask take at this edge
//   en_i, thr_i, timeout_i   IRQ_CTRL global enable, threshold, timeout
//   irq_q_i                  current registered irq (for hold)
//   irq_d_o                  next value of the registered irq
module gpio_intr_coalesce
    import gpio_intr_pkg::*;
#(
    parameter int NB_GPIO = 32,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic               mclk,
    input  logic               h_reset_n,
    input  logic [NB_GPIO-1:0] evt_i,
    input  logic [NB_GPIO-1:0] stat_i,
    input  logic [NB_GPIO-1:0] mask_i,
    input  logic [NB_GPIO-1:0] stat_next_i,
    input  logic [NB_GPIO-1:0] mask_next_i,
    input  logic               en_i,
    input  logic [7:0]         thr_i,
    input  logic [15:0]        timeout_i,
    input  logic               irq_q_i,
    output logic               irq_d_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             pend;
    logic             pend_next;
    logic             masked_evt;
    logic             trig;

    always_comb begin
        pend       = |(stat_i & mask_i);
        pend_next  = |(stat_next_i & mask_next_i);
        masked_evt = |(evt_i & mask_i);

        // Counters clear as soon as nothing masked will be pending after
        // this edge; otherwise events saturate-count and the timeout runs.
        cnt_d = cnt_q;
        tmo_d = tmo_q;
        if (!pend_next) begin
            cnt_d = '0;
            tmo_d = '0;
        end else begin
            if (masked_evt && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
            if ((cnt_q != '0) && (tmo_q != {TMO_W{1'b1}})) begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        // thr of 0 or 1 disables coalescing; once raised, irq holds.
        trig = irq_q_i
             || (thr_i <= 8'd1)
             || (32'(cnt_q) >= 32'(thr_i))
             || (32'(tmo_q) == 32'(timeout_i));

        irq_d_o = en_i & pend & trig;
    end

    always_ff @(posedge mclk) begin
        if (!h_reset_n) begin
            cnt_q <= '0;
            tmo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

endmodule

// File: rtl/gpio_intr_ctrl.sv
// rtl/gpio_intr_ctrl.sv - sticky GPIO interrupt status, mask and level irq; coalescing with GPIO_INTR_COALESCE_EN
//
// Ports:
//   mclk, h_reset_n   clock, synchronous active-low reset
//   gpio_int_event    one-cycle edge-event pulses, one per pin
//   reg_cs/reg_wr/reg_addr/reg_be/reg_wdata   register access request
//   reg_rdata/reg_ack read data and one-cycle acknowledge
//   gpio_irq          registered level interrupt
module gpio_intr_ctrl
    import gpio_intr_pkg::*;
#(
    parameter int NB_GPIO = 32,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic               mclk,
    input  logic               h_reset_n,
    input  logic [NB_GPIO-1:0] gpio_int_event,
    input  logic               reg_cs,
    input  logic               reg_wr,
    input  logic [1:0]         reg_addr,
    input  logic [3:0]         reg_be,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               reg_ack,
    output logic               gpio_irq
);

    if (NB_GPIO < 1 || NB_GPIO > 32 || CNT_W < 1 || TMO_W < 1) begin : g_bad_param
        $error("gpio_intr_ctrl: parameter out of range");
    end

`ifdef GPIO_INTR_COALESCE_EN
    localparam logic [31:0] CTRL_WMASK = 32'hFFFF_FF01;
`else
    localparam logic [31:0] CTRL_WMASK = 32'h0000_0001;
`endif

    bus_state_e         state_q, state_d;
    logic [NB_GPIO-1:0] stat_q, stat_d;
    logic [NB_GPIO-1:0] mask_q, mask_d;
    logic [31:0]        ctrl_q, ctrl_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               irq_q, irq_d;

    logic               commit;
    logic               wr;
    logic [31:0]        bm;
    logic [31:0]        wbits;
    logic [NB_GPIO-1:0] w1c;
    logic [NB_GPIO-1:0] w1s;
    logic [31:0]        rd_val;

    always_comb begin
        // A request is taken only from IDLE; the write commits on this edge.
        commit = (state_q == IDLE) && reg_cs;
        wr     = commit && reg_wr;
        bm     = be_to_mask(reg_be);
        wbits  = reg_wdata & bm;

        w1c = '0;
        w1s = '0;
        if (wr && reg_addr == INTR_STAT) w1c = wbits[NB_GPIO-1:0];
        if (wr && reg_addr == INTR_SET)  w1s = wbits[NB_GPIO-1:0];

        // Events are ORed in after the clear so a same-cycle event survives W1C.
        stat_d = (stat_q & ~w1c) | w1s | gpio_int_event;

        mask_d = mask_q;
        if (wr && reg_addr == INTR_MASK) begin
            mask_d = (mask_q & ~bm[NB_GPIO-1:0]) | wbits[NB_GPIO-1:0];
        end

        ctrl_d = ctrl_q;
        if (wr && reg_addr == IRQ_CTRL) begin
            ctrl_d = (ctrl_q & ~(bm & CTRL_WMASK)) | (wbits & CTRL_WMASK);
        end

        case (reg_addr)
            INTR_STAT: rd_val = 32'(stat_q);
            INTR_MASK: rd_val = 32'(mask_q);
            IRQ_CTRL:  rd_val = ctrl_q;
            default:   rd_val = 32'd0;
        endcase

        rdata_d = commit ? rd_val : rdata_q;
        state_d = commit ? ACK : IDLE;
    end

`ifdef GPIO_INTR_COALESCE_EN
    gpio_intr_coalesce #(
        .NB_GPIO (NB_GPIO),
        .CNT_W   (CNT_W),
        .TMO_W   (TMO_W)
    ) u_coalesce (
        .mclk        (mclk),
        .h_reset_n   (h_reset_n),
        .evt_i       (gpio_int_event),
        .stat_i      (stat_q),
        .mask_i      (mask_q),
        .stat_next_i (stat_d),
        .mask_next_i (mask_d),
        .en_i        (ctrl_q[CTRL_EN_BIT]),
        .thr_i       (ctrl_q[CTRL_THR_MSB:CTRL_THR_LSB]),
        .timeout_i   (ctrl_q[CTRL_TMO_MSB:CTRL_TMO_LSB]),
        .irq_q_i     (irq_q),
        .irq_d_o     (irq_d)
    );
`else
    assign irq_d = ctrl_q[CTRL_EN_BIT] & (|(stat_q & mask_q));
`endif

    always_ff @(posedge mclk) begin
        if (!h_reset_n) begin
            state_q <= IDLE;
            stat_q  <= '0;
            mask_q  <= '0;
            ctrl_q  <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            mask_q  <= mask_d;
            ctrl_q  <= ctrl_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign reg_ack   = (state_q == ACK);
    assign reg_rdata = rdata_q;
    assign gpio_irq  = irq_q;

endmodule

// File: tb/tb_gpio_intr_ctrl.sv
// tb/tb_gpio_intr_ctrl.sv - self-checking bench for gpio_intr_ctrl
module tb_gpio_intr_ctrl;

    logic        mclk = 1'b0;
    logic        h_reset_n;
    logic [31:0] gpio_int_event;
    logic        reg_cs;
    logic        reg_wr;
    logic [1:0]  reg_addr;
    logic [3:0]  reg_be;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        gpio_irq;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: register contents and expected outputs after each edge.
    logic [31:0] m_stat, m_mask, m_ctrl, exp_rdata;
    logic        m_busy, exp_ack, exp_irq;
    int          m_cnt, m_tmo;

    gpio_intr_ctrl #(.NB_GPIO(32), .CNT_W(8), .TMO_W(16)) dut (
        .mclk           (mclk),
        .h_reset_n      (h_reset_n),
        .gpio_int_event (gpio_int_event),
        .reg_cs         (reg_cs),
        .reg_wr         (reg_wr),
        .reg_addr       (reg_addr),
        .reg_be         (reg_be),
        .reg_wdata      (reg_wdata),
        .reg_rdata      (reg_rdata),
        .reg_ack        (reg_ack),
        .gpio_irq       (gpio_irq)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: advance the reference from the inputs seen at the edge,
    // then compare all outputs shortly after the edge.
    task automatic tick();
        logic [31:0] bm, wb, rd, w1c, w1s, ns, nm, nc, wmask;
        logic        commit, nirq, pend;
        int          thr, lim;
        @(posedge mclk);
        if (!h_reset_n) begin
            m_stat = 0; m_mask = 0; m_ctrl = 0; m_busy = 0;
            exp_ack = 0; exp_rdata = 0; exp_irq = 0;
            m_cnt = 0; m_tmo = 0;
        end else begin
            pend = (m_stat & m_mask) != 0;
            nirq = m_ctrl[0] && pend;
`ifdef GPIO_INTR_COALESCE_EN
            thr  = int'(m_ctrl[15:8]);
            lim  = int'(m_ctrl[31:16]);
            nirq = nirq && (exp_irq || thr <= 1 || m_cnt >= thr || m_tmo == lim);
            wmask = 32'hFFFF_FF01;
`else
            thr  = 0;
            lim  = 0;
            wmask = 32'h0000_0001;
`endif
            commit = reg_cs && !m_busy;
            for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{reg_be[b]}};
            wb = reg_wdata & bm;
            case (reg_addr)
                2'd0:    rd = m_stat;
                2'd2:    rd = m_mask;
                2'd3:    rd = m_ctrl;
                default: rd = 0;
            endcase
            w1c = (commit && reg_wr && reg_addr == 2'd0) ? wb : 0;
            w1s = (commit && reg_wr && reg_addr == 2'd1) ? wb : 0;
            ns  = (m_stat & ~w1c) | w1s | gpio_int_event;
            nm  = (commit && reg_wr && reg_addr == 2'd2) ? ((m_mask & ~bm) | wb) : m_mask;
            nc  = (commit && reg_wr && reg_addr == 2'd3) ? ((m_ctrl & ~(bm & wmask)) | (wb & wmask)) : m_ctrl;
            if ((ns & nm) == 0) begin
                m_cnt = 0; m_tmo = 0;
            end else begin
                if (m_cnt != 0 && m_tmo < 65535) m_tmo++;
                if ((gpio_int_event & m_mask) != 0 && m_cnt < 255) m_cnt++;
            end
            exp_ack = commit;
            if (commit) exp_rdata = rd;
            m_busy = commit;
            m_stat = ns; m_mask = nm; m_ctrl = nc;
            exp_irq = nirq;
        end
        #1;
        chk(32'(gpio_irq), 32'(exp_irq), "irq");
        chk(32'(reg_ack), 32'(exp_ack), "ack");
        chk(reg_rdata, exp_rdata, "rdata");
    endtask

    task automatic access(input logic w, input logic [1:0] a, input logic [3:0] be, input logic [31:0] d);
        reg_cs = 1; reg_wr = w; reg_addr = a; reg_be = be; reg_wdata = d;
        tick();
        reg_cs = 0; reg_wr = 0;
        tick();
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [31:0] exp, input string tag);
        reg_cs = 1; reg_wr = 0; reg_addr = a; reg_be = 0;
        tick();
        chk(reg_rdata, exp, tag);
        chk(32'(reg_ack), 32'd1, "ack_hi");
        reg_cs = 0;
        tick();
        chk(32'(reg_ack), 32'd0, "ack_lo");
    endtask

    task automatic pulse(input logic [31:0] e);
        gpio_int_event = e;
        tick();
        gpio_int_event = 0;
    endtask

    initial begin
        int waited;
        h_reset_n = 0; gpio_int_event = 0; reg_cs = 0; reg_wr = 0;
        reg_addr = 0; reg_be = 0; reg_wdata = 0;
        repeat (3) tick();
        h_reset_n = 1;
        tick();

        // Reset values readable at every address
        for (int a = 0; a < 4; a++) rd_chk(2'(a), 32'd0, "reset_read");

        // Masked event raises irq two edges after the pulse; W1C drops it
        access(1, 2'd2, 4'hF, 32'h1);
        access(1, 2'd3, 4'hF, 32'h1);
        pulse(32'h1);
        chk(32'(gpio_irq), 32'd0, "irq_lat1");
        tick();
        chk(32'(gpio_irq), 32'd1, "irq_lat2");
        rd_chk(2'd0, 32'h1, "stat_bit0");
        access(1, 2'd0, 4'hF, 32'h1);
        chk(32'(gpio_irq), 32'd0, "irq_w1c");

        // Event and W1C on the same bit in the same cycle: set wins
        gpio_int_event = 32'h20;
        reg_cs = 1; reg_wr = 1; reg_addr = 2'd0; reg_be = 4'hF; reg_wdata = 32'h20;
        tick();
        gpio_int_event = 0; reg_cs = 0; reg_wr = 0;
        tick();
        rd_chk(2'd0, 32'h20, "set_wins");

        // Unmasked event is sticky but silent until the mask opens
        access(1, 2'd2, 4'hF, 32'h0);
        access(1, 2'd0, 4'hF, 32'hFFFF_FFFF);
        pulse(32'h8);
        tick();
        chk(32'(gpio_irq), 32'd0, "irq_masked");
        rd_chk(2'd0, 32'h8, "stat_bit3");
        reg_cs = 1; reg_wr = 1; reg_addr = 2'd2; reg_be = 4'hF; reg_wdata = 32'h8;
        tick();
        reg_cs = 0; reg_wr = 0;
        tick();
        chk(32'(gpio_irq), 32'd1, "irq_mask_open");

        // Byte enables gate W1S
        access(1, 2'd0, 4'hF, 32'hFFFF_FFFF);
        access(1, 2'd1, 4'b1000, 32'h8000_0000);
        rd_chk(2'd0, 32'h8000_0000, "w1s_be_on");
        access(1, 2'd0, 4'hF, 32'hFFFF_FFFF);
        access(1, 2'd1, 4'b0111, 32'h8000_0000);
        rd_chk(2'd0, 32'h0, "w1s_be_off");
        rd_chk(2'd1, 32'h0, "set_reads0");

        // Reset on the commit edge discards the write and the ack
        reg_cs = 1; reg_wr = 1; reg_addr = 2'd2; reg_be = 4'hF; reg_wdata = 32'hFF;
        h_reset_n = 0;
        tick();
        chk(32'(reg_ack), 32'd0, "rst_no_ack");
        reg_cs = 0; reg_wr = 0; h_reset_n = 1;
        tick();
        rd_chk(2'd2, 32'h0, "rst_no_write");

        // Randomized traffic against the reference
        access(1, 2'd3, 4'hF, 32'h1);
        access(1, 2'd2, 4'hF, $urandom);
        for (int i = 0; i < 400; i++) begin
            gpio_int_event = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0)
                access(1'($urandom), 2'($urandom), 4'($urandom), $urandom);
            else
                tick();
        end
        gpio_int_event = 0;

`ifdef GPIO_INTR_COALESCE_EN
        // Coalescing: threshold 3, timeout 100
        h_reset_n = 0; tick(); h_reset_n = 1; tick();
        access(1, 2'd3, 4'hF, 32'h0064_0301);
        access(1, 2'd2, 4'hF, 32'hFFFF_FFFF);
        pulse(32'h4);
        waited = 0;
        while (gpio_irq !== 1'b1 && waited < 300) begin
            tick();
            waited++;
        end
        chk(32'(waited), 32'd101, "tmo_delay");
        access(1, 2'd0, 4'hF, 32'hFFFF_FFFF);
        tick();
        pulse(32'h1); tick(); tick();
        pulse(32'h2); tick(); tick();
        chk(32'(gpio_irq), 32'd0, "thr_before");
        pulse(32'h1);
        tick();
        chk(32'(gpio_irq), 32'd1, "thr_reached");
`else
        waited = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
